// File: rtl/cpu_types_pkg.sv
// Shared types for the pipelined MIPS datapath: machine word, instruction
// field encodings and the next-PC select used by the fetch stage.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Primary opcode field, instr[31:26]
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B,
        OP_HALT  = 6'h3F
    } opcode_t;

    // R-type function field, instr[5:0]
    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_JR   = 6'h08,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } funct_t;

    // Next-PC select, qualified by a redirect from a downstream stage
    typedef enum logic [1:0] {
        PC_NEXT = 2'd0,
        PC_BR   = 2'd1,
        PC_JUMP = 2'd2,
        PC_JR   = 2'd3
    } pcsrc_t;

    // sll $0,$0,0 -- the all-zero word doubles as the pipeline bubble
    localparam word_t NOP_INSTR = '0;
    localparam word_t PC_STEP   = 32'd4;

    // Sequential PC; wraps silently past 32'hFFFF_FFFC
    function automatic word_t pcIncrement(input word_t pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch-stage signals. The fs side is the stage itself, the tb
// side drives it; opcode/funct feed the control unit's decode inputs.
interface fetch_stage_if;
    import cpu_types_pkg::*;

    logic   ihit;
    word_t  imemload;
    logic   imemREN;
    word_t  imemaddr;
    logic   redirect;
    pcsrc_t PCSrc;
    word_t  br_target;
    word_t  j_target;
    word_t  jr_target;
    logic   stall;
    logic   halt;
    word_t  ifid_instr;
    word_t  ifid_npc;
    logic   ifid_valid;
    opcode_t opcode;
    funct_t  funct;

    modport fs (
        input  ihit, imemload, redirect, PCSrc, br_target, j_target,
               jr_target, stall, halt,
        output imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid,
               opcode, funct
    );

    modport tb (
        output ihit, imemload, redirect, PCSrc, br_target, j_target,
               jr_target, stall, halt,
        input  imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid,
               opcode, funct
    );

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Bubble beats load, load beats hold; reset clears
// the register to a nop that is marked invalid.
module ifid_reg
    import cpu_types_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_load,
    input  logic  i_bubble,
    input  word_t i_instr,
    input  word_t i_npc,
    output word_t o_instr,
    output word_t o_npc,
    output logic  o_valid
);

    word_t r_instr;
    word_t r_npc;
    logic  r_valid;

    // Capture, flush or hold the fetched instruction each cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instr <= NOP_INSTR;
            r_npc   <= '0;
            r_valid <= 1'b0;
        end else if (i_bubble) begin
            r_instr <= NOP_INSTR;
            r_npc   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_npc   <= i_npc;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_npc   = r_npc;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, next-PC selection, sticky halt
// and the IF/ID register. imemaddr is purely the PC register, so there is no
// combinational path from imemload back to the address.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic    CLK,
    input  logic    RST,
    input  logic    ihit,
    input  word_t   imemload,
    output logic    imemREN,
    output word_t   imemaddr,
    input  logic    redirect,
    input  pcsrc_t  PCSrc,
    input  word_t   br_target,
    input  word_t   j_target,
    input  word_t   jr_target,
    input  logic    stall,
    input  logic    halt,
    output word_t   ifid_instr,
    output word_t   ifid_npc,
    output logic    ifid_valid,
    output opcode_t opcode,
    output funct_t  funct
);

    word_t r_pc;
    logic  r_halted;

    word_t w_pcPlus4;
    word_t w_redirectPc;
    word_t w_nextPc;
    logic  w_stopped;
    logic  w_ifidLoad;
    logic  w_ifidBubble;

    assign w_pcPlus4 = pcIncrement(r_pc);
    assign w_stopped = r_halted | halt;

    // Target chosen by a resolved control transfer
    always_comb begin
        w_redirectPc = w_pcPlus4;
        case (PCSrc)
            PC_NEXT: w_redirectPc = w_pcPlus4;
            PC_BR:   w_redirectPc = br_target;
            PC_JUMP: w_redirectPc = j_target;
            PC_JR:   w_redirectPc = jr_target;
            default: w_redirectPc = w_pcPlus4;
        endcase
    end

    // Next PC and IF/ID control: halt, then redirect, then stall, then ihit
    always_comb begin
        w_nextPc     = r_pc;
        w_ifidLoad   = 1'b0;
        w_ifidBubble = 1'b0;
        if (w_stopped) begin
            w_ifidBubble = 1'b1;
        end else if (redirect) begin
            w_nextPc     = w_redirectPc;
            w_ifidBubble = 1'b1;
        end else if (stall) begin
            w_nextPc     = r_pc;
        end else if (ihit) begin
            w_nextPc     = w_pcPlus4;
            w_ifidLoad   = 1'b1;
        end else begin
            w_ifidBubble = 1'b1;
        end
    end

    // PC register; frozen once halted because w_nextPc holds
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc <= PC_INIT;
        end else begin
            r_pc <= w_nextPc;
        end
    end

    // Sticky halt flag, cleared only by reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_halted <= 1'b0;
        end else if (halt) begin
            r_halted <= 1'b1;
        end
    end

    ifid_reg u_ifidReg (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_load   (w_ifidLoad),
        .i_bubble (w_ifidBubble),
        .i_instr  (imemload),
        .i_npc    (w_pcPlus4),
        .o_instr  (ifid_instr),
        .o_npc    (ifid_npc),
        .o_valid  (ifid_valid)
    );

    assign imemREN  = ~r_halted;
    assign imemaddr = r_pc;
    assign opcode   = opcode_t'(ifid_instr[31:26]);
    assign funct    = funct_t'(ifid_instr[5:0]);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: each driven cycle pushes the expected
// post-edge state, which is popped and compared one time unit after the edge.
module tb_fetch_stage;
   import cpu_types_pkg::*;

   localparam word_t PC_INIT_TB = 32'h0000_0000;

   typedef struct {
      word_t pc;
      logic  ren;
      logic  valid;
      word_t instr;
      word_t npc;
   } expect_t;

   logic    CLK;
   logic    RST;
   logic    ihit;
   word_t   imemload;
   logic    imemREN;
   word_t   imemaddr;
   logic    redirect;
   pcsrc_t  PCSrc;
   word_t   br_target;
   word_t   j_target;
   word_t   jr_target;
   logic    stall;
   logic    halt;
   word_t   ifid_instr;
   word_t   ifid_npc;
   logic    ifid_valid;
   opcode_t opcode;
   funct_t  funct;

   int errors = 0;
   int checks = 0;

   expect_t sbQueue[$];

   word_t mPc;
   logic  mHalted;
   word_t mInstr;
   word_t mNpc;
   logic  mValid;

   fetch_stage #(.PC_INIT(PC_INIT_TB)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .ihit       (ihit),
      .imemload   (imemload),
      .imemREN    (imemREN),
      .imemaddr   (imemaddr),
      .redirect   (redirect),
      .PCSrc      (PCSrc),
      .br_target  (br_target),
      .j_target   (j_target),
      .jr_target  (jr_target),
      .stall      (stall),
      .halt       (halt),
      .ifid_instr (ifid_instr),
      .ifid_npc   (ifid_npc),
      .ifid_valid (ifid_valid),
      .opcode     (opcode),
      .funct      (funct)
   );

   // Free-running 10-unit clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Drive one cycle, advance the reference model, push the expectation,
   // then pop and compare it against the DUT after the edge
   task automatic applyStimulus(input logic rst, input logic hit, input word_t load,
                                input logic redir, input pcsrc_t src, input word_t tgt,
                                input logic stl, input logic hlt);
      expect_t e;
      word_t   seq;
      RST       = rst;
      ihit      = hit;
      imemload  = load;
      redirect  = redir;
      PCSrc     = src;
      br_target = (src == PC_BR)   ? tgt : $urandom;
      j_target  = (src == PC_JUMP) ? tgt : $urandom;
      jr_target = (src == PC_JR)   ? tgt : $urandom;
      stall     = stl;
      halt      = hlt;

      seq = mPc + 32'd4;
      if (rst) begin
         mPc = PC_INIT_TB; mHalted = 1'b0;
         mInstr = '0; mNpc = '0; mValid = 1'b0;
      end else if (mHalted || hlt) begin
         mHalted = 1'b1;
         mInstr = '0; mValid = 1'b0;
      end else if (redir) begin
         mPc = (src == PC_NEXT) ? seq : tgt;
         mInstr = '0; mValid = 1'b0;
      end else if (stl) begin
         // hold everything
      end else if (hit) begin
         mInstr = load; mNpc = seq; mValid = 1'b1; mPc = seq;
      end else begin
         mInstr = '0; mValid = 1'b0;
      end

      e.pc = mPc; e.ren = ~mHalted; e.valid = mValid; e.instr = mInstr; e.npc = mNpc;
      sbQueue.push_back(e);

      @(posedge CLK);
      #1;
      e = sbQueue.pop_front();
      checkOutput("imemaddr", imemaddr, e.pc);
      checkOutput("imemREN", {31'd0, imemREN}, {31'd0, e.ren});
      checkOutput("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.valid});
      checkOutput("ifid_instr", ifid_instr, e.instr);
      checkOutput("opcode", {26'd0, opcode}, {26'd0, e.instr[31:26]});
      checkOutput("funct", {26'd0, funct}, {26'd0, e.instr[5:0]});
      if (e.valid) checkOutput("ifid_npc", ifid_npc, e.npc);
   endtask

   initial begin
      mPc = PC_INIT_TB; mHalted = 1'b0; mInstr = '0; mNpc = '0; mValid = 1'b0;
      RST = 1'b1; ihit = 1'b0; imemload = '0; redirect = 1'b0; PCSrc = PC_NEXT;
      br_target = '0; j_target = '0; jr_target = '0; stall = 1'b0; halt = 1'b0;
      $display("[TB] start");

      // Reset held two cycles with ihit high: pc must not move
      applyStimulus(1, 1, 32'hDEAD_BEEF, 0, PC_NEXT, 0, 0, 0);
      applyStimulus(1, 1, 32'hDEAD_BEEF, 0, PC_NEXT, 0, 0, 0);
      checkOutput("reset_pc", imemaddr, 32'h0);
      checkOutput("reset_ren", {31'd0, imemREN}, 32'd1);

      // Streaming two words
      applyStimulus(0, 1, 32'h2001_0005, 0, PC_NEXT, 0, 0, 0);
      checkOutput("stream_npc0", ifid_npc, 32'h4);
      applyStimulus(0, 1, 32'h0022_1820, 0, PC_NEXT, 0, 0, 0);
      checkOutput("stream_pc8", imemaddr, 32'h8);
      checkOutput("stream_opcode", {26'd0, opcode}, 32'h0);
      checkOutput("stream_funct", {26'd0, funct}, 32'h20);

      // Wait states at pc=8, then the fetch completes
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h1111_1111, 0, PC_NEXT, 0, 0, 0);
      applyStimulus(0, 1, 32'h8C43_0004, 0, PC_NEXT, 0, 0, 0);
      checkOutput("wait_resume_npc", ifid_npc, 32'hC);

      // Stall two cycles with ihit, then release
      applyStimulus(0, 1, 32'h2222_2222, 0, PC_NEXT, 0, 1, 0);
      applyStimulus(0, 1, 32'h3333_3333, 0, PC_NEXT, 0, 1, 0);
      checkOutput("stall_hold_instr", ifid_instr, 32'h8C43_0004);
      applyStimulus(0, 1, 32'hAC43_0008, 0, PC_NEXT, 0, 0, 0);

      // Redirects: branch beats stall, jr with no ihit, jump, sequential
      applyStimulus(0, 1, 32'h4444_4444, 1, PC_BR, 32'h40, 1, 0);
      checkOutput("br_target_pc", imemaddr, 32'h40);
      applyStimulus(0, 1, 32'h3C01_1234, 0, PC_NEXT, 0, 0, 0);
      applyStimulus(0, 0, 32'h5555_5555, 1, PC_JR, 32'h100, 0, 0);
      checkOutput("jr_target_pc", imemaddr, 32'h100);
      applyStimulus(0, 1, 32'h6666_6666, 1, PC_JUMP, 32'h0000_0203, 0, 0);
      applyStimulus(0, 1, 32'h7777_7777, 1, PC_NEXT, 32'h0, 0, 0);

      // PC wrap past the top of the address space
      applyStimulus(0, 0, 32'h0, 1, PC_JUMP, 32'hFFFF_FFFC, 0, 0);
      applyStimulus(0, 1, 32'h0000_0008, 0, PC_NEXT, 0, 0, 0);
      checkOutput("wrap_pc", imemaddr, 32'h0);

      // Random mix without halt
      for (int i = 0; i < 40; i++) begin
         applyStimulus(0, 1'($urandom_range(0, 1)), $urandom,
                       ($urandom_range(0, 7) == 0), pcsrc_t'($urandom_range(0, 3)),
                       $urandom, ($urandom_range(0, 3) == 0), 0);
      end

      // Halt together with a redirect: pc frozen, fetch disabled, bubbles
      applyStimulus(0, 1, 32'h8888_8888, 1, PC_BR, 32'h80, 0, 1);
      checkOutput("halt_ren", {31'd0, imemREN}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, $urandom, 1'($urandom_range(0, 1)), PC_JUMP, 32'h80, 0, 0);
      end

      // Reset clears halt; ihit in the reset cycle is ignored
      applyStimulus(1, 1, 32'h9999_9999, 0, PC_NEXT, 0, 0, 0);
      checkOutput("post_halt_reset_pc", imemaddr, PC_INIT_TB);
      checkOutput("post_halt_reset_ren", {31'd0, imemREN}, 32'd1);
      applyStimulus(0, 1, 32'h2001_0005, 0, PC_NEXT, 0, 0, 0);

      // Mid-fetch reset
      applyStimulus(0, 1, 32'h0022_1820, 0, PC_NEXT, 0, 0, 0);
      applyStimulus(1, 1, 32'hABCD_0000, 0, PC_NEXT, 0, 0, 0);
      applyStimulus(0, 1, 32'h2001_0005, 0, PC_NEXT, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
